// File: rtl/axis_pulse_sequencer.sv
// AXI4-Stream pulse sequencer: each command {gap, width, amp} becomes `width`
// beats of amp followed by `gap` zero beats, paced by downstream back-pressure.
module axis_pulse_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNTR_WIDTH = 32,
  parameter int CONTINUOUS = 0
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [DATA_WIDTH+2*CNTR_WIDTH-1:0] s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             busy
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  typedef struct packed {
    logic [CNTR_WIDTH-1:0] gap;
    logic [CNTR_WIDTH-1:0] width;
    logic [DATA_WIDTH-1:0] amp;
  } cmd_t;

  cmd_t                  cmd;
  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] amp_reg, amp_n;
  logic [CNTR_WIDTH-1:0] cntr, cntr_n;
  logic [CNTR_WIDTH-1:0] gap_reg, gap_n;
  logic                  beat, cnt_one, last, accept;

  assign cmd = cmd_t'(s_axis_tdata);

  // Outputs are gated by aresetn so nothing is presented while reset is held.
  assign m_axis_tvalid = aresetn & ((state != IDLE) | (CONTINUOUS != 0));
  assign m_axis_tdata  = (state == PULSE) ? amp_reg : '0;
  assign busy          = (state != IDLE);

  assign beat    = m_axis_tvalid & m_axis_tready;
  assign cnt_one = (cntr == CNTR_WIDTH'(1));
  assign last    = beat & cnt_one &
                   (((state == PULSE) & (gap_reg == '0)) | (state == GAP));

  assign s_axis_tready = aresetn & ((state == IDLE) | last);
  assign accept        = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      amp_reg <= '0;
      cntr    <= '0;
      gap_reg <= '0;
    end else begin
      state   <= state_n;
      amp_reg <= amp_n;
      cntr    <= cntr_n;
      gap_reg <= gap_n;
    end
  end

  always_comb begin
    state_n = state;
    amp_n   = amp_reg;
    cntr_n  = cntr;
    gap_n   = gap_reg;
    if (accept) begin
      // Acceptance only happens in IDLE or on the final beat, so a load
      // always supersedes the end-of-sequence transition.
      if (cmd.width != '0) begin
        amp_n   = cmd.amp;
        cntr_n  = cmd.width;
        gap_n   = cmd.gap;
        state_n = PULSE;
      end else if (cmd.gap != '0) begin
        cntr_n  = cmd.gap;
        gap_n   = '0;
        state_n = GAP;
      end else begin
        state_n = IDLE;
      end
    end else if (beat && state != IDLE) begin
      if (cnt_one) begin
        if (state == PULSE && gap_reg != '0) begin
          cntr_n  = gap_reg;
          state_n = GAP;
        end else begin
          state_n = IDLE;
        end
      end else begin
        cntr_n = cntr - CNTR_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/axis_pulse_sequencer.md
# axis_pulse_sequencer

Parametrised AXI4-Stream pulse sequencer that turns a stream of pulse commands (amplitude, pulse width, gap) into a continuous sample stream for a DAC path. Each command produces `width` output beats carrying the amplitude, then `gap` beats of zero. Unlike the single-shot pulse generator, it honours downstream back-pressure, counts in transferred beats, and accepts the next command on the final beat so consecutive pulses stay gapless. It sits between a command FIFO (fed from the PS) and the DAC sample stream.

## Interface
- `DATA_WIDTH`, 16, amplitude/sample width in bits.
- `CNTR_WIDTH`, 32, width of the pulse-width and gap counters.
- `CONTINUOUS`, 0, when 1 the master stream stays valid with zero samples while idle. When 0 it is not valid while idle.

- `aclk`  in  1  clock; all logic is on the rising edge.
- `aresetn`  in  1  reset: one clock, asynchronous assertion, active-low.
- `s_axis_tdata`  in  DATA_WIDTH+2*CNTR_WIDTH  command word. `[DATA_WIDTH-1:0]` is amp, `[DATA_WIDTH+CNTR_WIDTH-1:DATA_WIDTH]` is width, and the top CNTR_WIDTH bits are gap.
- `s_axis_tvalid`  in  1  command valid.
- `s_axis_tready`  out  1  command accepted when high together with tvalid.
- `m_axis_tdata`  out  DATA_WIDTH  output sample.
- `m_axis_tvalid`  out  1  output sample valid.
- `m_axis_tready`  in  1  downstream ready.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States are IDLE, PULSE and GAP. Registers are `state`, `amp_reg` (DATA_WIDTH), `cntr` (CNTR_WIDTH) and `gap_reg` (CNTR_WIDTH).
- beat = m_axis_tvalid & m_axis_tready. Counters decrement only on beats. A stalled downstream freezes the sequence.
- m_axis_tdata = amp_reg in PULSE, otherwise 0.
- m_axis_tvalid = 1 in PULSE or GAP. In IDLE it equals CONTINUOUS. Beats that occur in IDLE are not counted.
- last = beat & (cntr == 1) & (PULSE with gap_reg == 0, or GAP).
- s_axis_tready = aresetn & (state == IDLE | last).
- Command load on acceptance, selecting the next state:
  - width != 0: amp_reg <= amp, cntr <= width, gap_reg <= gap, go to PULSE.
  - width == 0 and gap != 0: cntr <= gap, go to GAP. Output in GAP is zero.
  - width == 0 and gap == 0: the command is consumed and the state goes to IDLE. No beats are produced.
- PULSE, on a beat with cntr == 1:
  - gap_reg != 0: cntr <= gap_reg, go to GAP.
  - Otherwise, this is `last`: if a command is accepted in the same cycle, load it; else go to IDLE.
- GAP, on a beat with cntr == 1 (`last`): if a command is accepted in the same cycle, load it; else go to IDLE.
- Any other beat in PULSE or GAP: cntr <= cntr - 1. The counter never wraps, because it is reloaded at 1.
- Maximum width and maximum gap are each 2^CNTR_WIDTH-1 beats.
- amp is not sign-interpreted; it is passed through bit-exact.

## Timing
- Reset asserted (asynchronously): state=IDLE, cntr=0, gap_reg=0, amp_reg=0.
  - While aresetn is low: s_axis_tready=0, m_axis_tvalid=0 (regardless of CONTINUOUS), m_axis_tdata=0, busy=0.
  - Reset mid-pulse aborts immediately. The command in progress is lost.
- First rising edge after release: s_axis_tready=1 in IDLE.
- Latency: a command accepted at edge N presents its first beat from edge N onward, i.e. valid in cycle N+1.
- Back-to-back: with m_axis_tready held high, pulse k+1's first beat directly follows pulse k's last beat (or last gap beat), with zero idle cycles.
- s_axis_tready depends combinationally on m_axis_tready, only during the final beat. There is no combinational path from s_axis_tvalid to any output.
- Holding m_axis_tready low: tdata, tvalid and the state are stable; nothing is accepted except in IDLE.

## Test plan
- Single pulse, CONTINUOUS=0, m_axis_tready=1. Command amp=0x1234, width=3, gap=2. Required response: exactly 3 beats of 0x1234 then 2 beats of 0x0000, then tvalid=0; busy high for 5 cycles.
- Back-to-back with commands pre-queued: (0x0100,2,0), then (0x0200,1,1). Required output: 0x0100, 0x0100, 0x0200, 0x0000 on 4 consecutive cycles. s_axis_tready pulses on cycle 2 (last beat of the first command).
- Back-pressure: command (0x00AA,4,0) with m_axis_tready toggling 1,0,0,1,1,0,1. Required: exactly 4 beats of 0x00AA, and tdata stable during stalls. s_axis_tready rises only on the 4th beat.
- Zero fields:
  - (0x7FFF,0,3) must produce 3 zero beats and no amplitude beat.
  - (0x7FFF,0,0) must be accepted in one cycle with no output and busy=0.
- CONTINUOUS=1 idle: no commands. Required: tvalid=1, tdata=0 every cycle. Then (0x0001,1,0) produces one beat of 0x0001 and returns to zeros.
- Reset mid-pulse: command (0x5555,100,0); assert aresetn at beat 10. Required: tvalid=0 and s_axis_tready=0 immediately. After release, tready=1 and no residual 0x5555 beats.
